// File: rtl/clmul_slice_sched_if.sv
// rtl/clmul_slice_sched_if.sv - two-requester operand bus and product bus for clmul_slice_sched
interface clmul_slice_sched_if #(
  parameter int W = 16
);
  logic           in0_valid;
  logic [W-1:0]   in0_a;
  logic [W-1:0]   in0_b;
  logic           in0_ready;
  logic           in1_valid;
  logic [W-1:0]   in1_a;
  logic [W-1:0]   in1_b;
  logic           in1_ready;
  logic           out_valid;
  logic [2*W-1:0] out_data;
  logic           out_id;
  logic           out_ready;

  // Requesters and consumer side
  modport master (
    output in0_valid, in0_a, in0_b, input in0_ready,
    output in1_valid, in1_a, in1_b, input in1_ready,
    input out_valid, out_data, out_id, output out_ready
  );

  // Multiplier side
  modport slave (
    input in0_valid, in0_a, in0_b, output in0_ready,
    input in1_valid, in1_a, in1_b, output in1_ready,
    output out_valid, out_data, out_id, input out_ready
  );
endinterface

// File: rtl/clmul_slice_sched.sv
// rtl/clmul_slice_sched.sv - carry-less multiplier time-sharing one 8x8 slice, two round-robin requesters
module clmul_slice_sched #(
  parameter int W = 16
) (
  input logic               clk,
  input logic               rst,
  clmul_slice_sched_if.slave bus
);
  localparam int NB = W / 8;
  localparam int S  = NB * NB;
  localparam int SW = $clog2(S);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   a_q, b_q;
  logic           id_q;
  logic           last_q;
  logic [SW-1:0]  step_q;
  logic [2*W-1:0] acc_q;

  logic           grant;
  logic           rdy0, rdy1;
  logic           accept;
  int             ci, cj;
  logic [7:0]     ca, cb;
  logic [14:0]    slice;
  logic [2*W-1:0] term;

  // Round-robin grant: a lone requester wins, a tie goes to the one not served last
  always_comb begin
    grant  = (bus.in0_valid && bus.in1_valid) ? ~last_q : bus.in1_valid;
    rdy0   = (state == IDLE) && !rst && bus.in0_valid && !grant;
    rdy1   = (state == IDLE) && !rst && bus.in1_valid && grant;
    accept = rdy0 || rdy1;
  end

  // Single shared 8x8 slice: chunk i of A against chunk j of B, placed at byte i+j
  always_comb begin
    ci    = int'(step_q) / NB;
    cj    = int'(step_q) % NB;
    ca    = a_q[8*ci +: 8];
    cb    = b_q[8*cj +: 8];
    slice = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        slice[i+j] = slice[i+j] ^ (ca[i] & cb[j]);
    term  = {{(2*W-15){1'b0}}, slice} << (8 * (ci + cj));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: one RUN cycle per slice step, then hold the result until taken
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (step_q == SW'(S - 1)) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: ready only in IDLE, product only in DONE
  always_comb begin
    bus.in0_ready = rdy0;
    bus.in1_ready = rdy1;
    bus.out_valid = (state == DONE);
    bus.out_data  = (state == DONE) ? acc_q : '0;
    bus.out_id    = (state == DONE) ? id_q : 1'b0;
  end

  // Operand capture, step counter, accumulator and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      id_q   <= 1'b0;
      last_q <= 1'b1;
      step_q <= '0;
      acc_q  <= '0;
    end else if (accept) begin
      a_q    <= grant ? bus.in1_a : bus.in0_a;
      b_q    <= grant ? bus.in1_b : bus.in0_b;
      id_q   <= grant;
      last_q <= grant;
      step_q <= '0;
      acc_q  <= '0;
    end else if (state == RUN) begin
      acc_q  <= acc_q ^ term;
      step_q <= step_q + SW'(1);
    end
  end
endmodule

// File: tb/tb_clmul_slice_sched.sv
// tb/tb_clmul_slice_sched.sv - self-checking bench for clmul_slice_sched at W=16 and W=32
module tb_clmul_slice_sched;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clmul_slice_sched_if #(.W(16)) bus16 ();
  clmul_slice_sched_if #(.W(32)) bus32 ();

  clmul_slice_sched #(.W(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  clmul_slice_sched #(.W(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state for the W=16 instance
  bit          m_on   = 0;
  bit          m_pend = 0;
  bit          m_done = 0;
  bit          m_last = 1;
  bit          m_id   = 0;
  int          m_wait = 0;
  logic [31:0] m_data = '0;

  // Observed handshakes on the W=16 instance
  logic [31:0] xq_data[$];
  bit          xq_id[$];
  int          xq_cyc[$];
  bit          aq_id[$];
  int          aq_cyc[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Shift-and-xor polynomial product over GF(2)
  function automatic logic [31:0] gf_mul16(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      if (a[i]) r = r ^ (32'(b) << i);
    return r;
  endfunction

  // Log handshakes and advance the transaction-level model at each edge
  always @(posedge clk) begin
    m_on = 1;
    if (!rst && bus16.out_valid && bus16.out_ready) begin
      xq_data.push_back(bus16.out_data);
      xq_id.push_back(bus16.out_id);
      xq_cyc.push_back(cyc);
    end
    if (!rst && ((bus16.in0_valid && bus16.in0_ready) || (bus16.in1_valid && bus16.in1_ready))) begin
      aq_id.push_back(bus16.in1_ready);
      aq_cyc.push_back(cyc);
    end
    if (rst) begin
      m_pend = 0;
      m_done = 0;
      m_last = 1;
    end else if (m_done) begin
      if (bus16.out_ready) m_done = 0;
    end else if (m_pend) begin
      m_wait--;
      if (m_wait == 0) begin
        m_pend = 0;
        m_done = 1;
      end
    end else if (bus16.in0_valid || bus16.in1_valid) begin
      m_id   = (bus16.in0_valid && bus16.in1_valid) ? !m_last : bus16.in1_valid;
      m_data = m_id ? gf_mul16(bus16.in1_a, bus16.in1_b) : gf_mul16(bus16.in0_a, bus16.in0_b);
      m_last = m_id;
      m_pend = 1;
      m_wait = S;
    end
    cyc++;
  end

  // Cycle-by-cycle comparison of the W=16 outputs against the model
  always @(negedge clk) begin
    bit idle, e0, e1;
    if (m_on) begin
      idle = !rst && !m_pend && !m_done;
      e0   = idle && bus16.in0_valid && (!bus16.in1_valid || m_last);
      e1   = idle && bus16.in1_valid && (!bus16.in0_valid || !m_last);
      chk("in0_ready", bus16.in0_ready, e0);
      chk("in1_ready", bus16.in1_ready, e1);
      chk("ready_exclusive", bus16.in0_ready & bus16.in1_ready, 0);
      chk("out_valid", bus16.out_valid, m_done);
      chk("out_data", bus16.out_data, m_done ? m_data : 32'h0);
      chk("out_id", bus16.out_id, m_done ? m_id : 1'b0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send16(input bit port, input logic [15:0] a, input logic [15:0] b);
    bit ok;
    ok = 0;
    if (port) begin
      bus16.in1_valid = 1; bus16.in1_a = a; bus16.in1_b = b;
    end else begin
      bus16.in0_valid = 1; bus16.in0_a = a; bus16.in0_b = b;
    end
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (port ? bus16.in1_ready : bus16.in0_ready) ok = 1;
      @(posedge clk);
      #1;
    end
    if (port) bus16.in1_valid = 0;
    else      bus16.in0_valid = 0;
    chk("accept_in_time", ok, 1);
  endtask

  task automatic wait_xfers(input int n);
    for (int k = 0; k < 80 && xq_data.size() < n; k++) tick(1);
    chk("xfer_in_time", xq_data.size() >= n, 1);
  endtask

  task automatic wait_accepts(input int n);
    for (int k = 0; k < 80 && aq_id.size() < n; k++) tick(1);
    chk("accept_count_in_time", aq_id.size() >= n, 1);
  endtask

  initial begin
    int  base, nx, na, edges;
    bit  ok, seen;

    rst = 1;
    bus16.in0_valid = 0; bus16.in0_a = '0; bus16.in0_b = '0;
    bus16.in1_valid = 0; bus16.in1_a = '0; bus16.in1_b = '0;
    bus16.out_ready = 0;
    bus32.in0_valid = 0; bus32.in0_a = '0; bus32.in0_b = '0;
    bus32.in1_valid = 0; bus32.in1_a = '0; bus32.in1_b = '0;
    bus32.out_ready = 0;
    tick(3);

    // Reset state, including readies held low while a requester is valid
    bus16.in0_valid = 1;
    bus16.in1_valid = 1;
    #1;
    chk("rst_in0_ready", bus16.in0_ready, 0);
    chk("rst_in1_ready", bus16.in1_ready, 0);
    chk("rst_out_valid", bus16.out_valid, 0);
    chk("rst_out_data", bus16.out_data, 0);
    chk("rst_out_id", bus16.out_id, 0);
    chk("rst_out_valid_w32", bus32.out_valid, 0);
    bus16.in0_valid = 0;
    bus16.in1_valid = 0;
    tick(1);
    rst = 0;
    bus16.out_ready = 1;
    tick(2);

    // Basic products and latency
    send16(0, 16'h0003, 16'h0003);
    wait_xfers(1);
    chk("p3x3_data", xq_data[0], 32'h0000_0005);
    chk("p3x3_id", xq_id[0], 0);
    chk("p3x3_latency", xq_cyc[0] - aq_cyc[0], S + 1);
    send16(0, 16'hFFFF, 16'hFFFF);
    wait_xfers(2);
    chk("pffff_data", xq_data[1], 32'h5555_5555);
    send16(1, 16'h8000, 16'h8000);
    wait_xfers(3);
    chk("p8000_data", xq_data[2], 32'h4000_0000);
    chk("p8000_id", xq_id[2], 1);

    // Both requesters continuously valid: alternating grants, fixed spacing
    base = aq_id.size();
    bus16.in0_a = 16'h0003; bus16.in0_b = 16'h0005;
    bus16.in1_a = 16'h0007; bus16.in1_b = 16'h0003;
    bus16.in0_valid = 1;
    bus16.in1_valid = 1;
    wait_accepts(base + 4);
    bus16.in0_valid = 0;
    bus16.in1_valid = 0;
    wait_xfers(7);
    for (int k = 0; k < 4; k++) begin
      chk("alt_id", aq_id[base+k], k % 2);
      chk("alt_data", xq_data[3+k], (k % 2) ? 32'h9 : 32'hF);
      if (k > 0) chk("alt_gap", aq_cyc[base+k] - aq_cyc[base+k-1], S + 2);
    end

    // Back-pressure in DONE with the other requester waiting
    bus16.out_ready = 0;
    send16(0, 16'h1234, 16'h0101);
    bus16.in1_a = 16'h0002; bus16.in1_b = 16'h0002;
    bus16.in1_valid = 1;
    tick(S);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stall_out_valid", bus16.out_valid, 1);
      chk("stall_out_data", bus16.out_data, 32'h0012_2634);
      chk("stall_out_id", bus16.out_id, 0);
      chk("stall_in1_ready", bus16.in1_ready, 0);
      @(posedge clk);
      #1;
    end
    nx = xq_data.size();
    na = aq_id.size();
    bus16.out_ready = 1;
    wait_accepts(na + 1);
    bus16.in1_valid = 0;
    wait_xfers(nx + 2);
    chk("stall_release_data", xq_data[nx], 32'h0012_2634);
    chk("stall_next_data", xq_data[nx+1], 32'h4);
    chk("stall_next_id", xq_id[nx+1], 1);
    chk("stall_xfer_gap", xq_cyc[nx+1] - xq_cyc[nx], S + 2);

    // Reset in the middle of RUN discards the operation
    nx = xq_data.size();
    send16(0, 16'hFFFF, 16'h00FF);
    tick(2);
    rst = 1;
    tick(1);
    rst = 0;
    chk("abort_out_valid", bus16.out_valid, 0);
    chk("abort_out_data", bus16.out_data, 0);
    tick(10);
    chk("abort_no_output", xq_data.size(), nx);

    // After reset a tie goes to requester 0 again
    na = aq_id.size();
    bus16.in0_a = 16'h0003; bus16.in0_b = 16'h0005;
    bus16.in1_a = 16'h0007; bus16.in1_b = 16'h0003;
    bus16.in0_valid = 1;
    bus16.in1_valid = 1;
    wait_accepts(na + 1);
    bus16.in0_valid = 0;
    bus16.in1_valid = 0;
    chk("post_rst_grant", aq_id[na], 0);
    wait_xfers(nx + 1);
    chk("post_rst_data", xq_data[nx], 32'hF);

    // W=32 instance: sixteen slice steps
    bus32.in0_a = 32'h0000_0101;
    bus32.in0_b = 32'h0001_0001;
    bus32.in0_valid = 1;
    ok = 0;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk);
      if (bus32.in0_ready) ok = 1;
      @(posedge clk);
      #1;
    end
    bus32.in0_valid = 0;
    chk("w32_accept", ok, 1);
    edges = 0;
    seen  = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (bus32.out_valid) seen = 1;
      else begin
        @(posedge clk);
        edges++;
      end
    end
    chk("w32_latency", edges, 16);
    chk("w32_data", bus32.out_data, 64'h0000_0000_0101_0101);
    chk("w32_id", bus32.out_id, 0);
    @(posedge clk);
    #1;
    bus32.out_ready = 1;
    tick(1);
    bus32.out_ready = 0;
    chk("w32_released", bus32.out_valid, 0);

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
